// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: definitions shared by the ALU arbiter, its round-robin
// grant logic and the shared combinational ALU.
//   - DATA_W / OP_W : operand and opcode widths
//   - OP_*          : opcode encodings (100..111 are reserved, result 0)
//   - state_e       : arbiter FSM states
package alu_arb_pkg;

   localparam int DATA_W = 8;
   localparam int OP_W   = 3;

   localparam logic [OP_W-1:0] OP_ADD = 3'b000;
   localparam logic [OP_W-1:0] OP_SUB = 3'b001;
   localparam logic [OP_W-1:0] OP_AND = 3'b010;
   localparam logic [OP_W-1:0] OP_OR  = 3'b011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

endpackage

// File: rtl/alu.sv
// alu: shared 8-bit combinational ALU.
// Ports:
//   a_i, b_i  in  DATA_W  operands
//   op_i      in  OP_W    opcode (add/sub/and/or; others give 0)
//   result_o  out DATA_W  result, wrap-around, no carry out
//   zero_o    out 1       result == 0
module alu
   import alu_arb_pkg::*;
(
   input  logic [DATA_W-1:0] a_i,
   input  logic [DATA_W-1:0] b_i,
   input  logic [OP_W-1:0]   op_i,
   output logic [DATA_W-1:0] result_o,
   output logic              zero_o
);

   always_comb begin
      case (op_i)
         OP_ADD:  result_o = a_i + b_i;
         OP_SUB:  result_o = a_i - b_i;
         OP_AND:  result_o = a_i & b_i;
         OP_OR:   result_o = a_i | b_i;
         default: result_o = '0;
      endcase
   end

   assign zero_o = (result_o == '0);

endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin grant logic. Picks the first asserted request at
// or above ptr_i, wrapping around at N.
// Ports:
//   req_i  in  N      request vector
//   ptr_i  in  IDX_W  highest-priority index (must be < N)
//   gnt_o  out N      one-hot grant (zero when no request)
//   idx_o  out IDX_W  binary index of the granted request
//   any_o  out 1      at least one request is asserted
module rr_arbiter #(
   parameter int N     = 4,
   parameter int IDX_W = 2
) (
   input  logic [N-1:0]     req_i,
   input  logic [IDX_W-1:0] ptr_i,
   output logic [N-1:0]     gnt_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             any_o
);

   always_comb begin
      int   pos;
      logic found;
      gnt_o = '0;
      idx_o = '0;
      found = 1'b0;
      pos   = 0;
      for (int k = 0; k < N; k++) begin
         // ptr_i < N and k < N, so a single subtraction performs the wrap
         pos = int'(ptr_i) + k;
         if (pos >= N) pos = pos - N;
         if (!found && req_i[pos]) begin
            found      = 1'b1;
            gnt_o[pos] = 1'b1;
            idx_o      = IDX_W'(pos);
         end
      end
   end

   assign any_o = |req_i;

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU among NUM_REQ clients.
// Round-robin grant in IDLE, one EXEC cycle on latched operands, then the
// registered response is held in RESP until rsp_valid && rsp_ready.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   per-client request handshake (ready one-hot or 0)
//   req_a/req_b/req_op    packed per-client operands and opcode
//   rsp_valid/rsp_ready   response handshake
//   rsp_id/rsp_result/rsp_zero  registered response
//   grant_count           (only with ALU_ARB_STATS_EN) saturating count of
//                         completed response handshakes
// Optional feature macro: ALU_ARB_STATS_EN
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_REQ-1:0]      req_valid,
   output logic [NUM_REQ-1:0]      req_ready,
   input  logic [NUM_REQ*8-1:0]    req_a,
   input  logic [NUM_REQ*8-1:0]    req_b,
   input  logic [NUM_REQ*3-1:0]    req_op,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [DATA_W-1:0]       rsp_result,
   output logic                    rsp_zero
`ifdef ALU_ARB_STATS_EN
   ,
   output logic [15:0]             grant_count
`endif
);

   state_e              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;

   logic [NUM_REQ-1:0]  gnt;
   logic [ID_W-1:0]     gnt_idx;
   logic                gnt_any;
   logic                accept;

   logic [DATA_W-1:0]   a_q, b_q;
   logic [OP_W-1:0]     op_q;
   logic [ID_W-1:0]     id_q;

   logic [DATA_W-1:0]   alu_result;
   logic                alu_zero;

   logic [DATA_W-1:0]   rsp_result_q;
   logic                rsp_zero_q;
   logic [ID_W-1:0]     rsp_id_q;

   rr_arbiter #(
      .N     (NUM_REQ),
      .IDX_W (ID_W)
   ) u_rr (
      .req_i (req_valid),
      .ptr_i (rr_ptr_q),
      .gnt_o (gnt),
      .idx_o (gnt_idx),
      .any_o (gnt_any)
   );

   alu u_alu (
      .a_i      (a_q),
      .b_i      (b_q),
      .op_i     (op_q),
      .result_o (alu_result),
      .zero_o   (alu_zero)
   );

   assign accept = (state_q == IDLE) && gnt_any;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      case (state_q)
         IDLE: begin
            if (gnt_any) begin
               state_d  = EXEC;
               rr_ptr_d = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
            end
         end
         EXEC:    state_d = RESP;
         RESP:    if (rsp_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs; req_ready is gated by rst_n so nothing is granted while the
   // async reset holds the FSM in IDLE.
   always_comb begin
      req_ready = '0;
      if ((state_q == IDLE) && rst_n) req_ready = gnt;
      rsp_valid = (state_q == RESP);
   end

   // Operand capture: data only, consumed solely in EXEC, so no reset needed
   always_ff @(posedge clk) begin
      if (accept) begin
         a_q  <= req_a[int'(gnt_idx)*DATA_W +: DATA_W];
         b_q  <= req_b[int'(gnt_idx)*DATA_W +: DATA_W];
         op_q <= req_op[int'(gnt_idx)*OP_W +: OP_W];
         id_q <= gnt_idx;
      end
   end

   // Response registers, loaded at the end of EXEC and held through RESP
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_result_q <= '0;
         rsp_zero_q   <= 1'b0;
         rsp_id_q     <= '0;
      end else if (state_q == EXEC) begin
         rsp_result_q <= alu_result;
         rsp_zero_q   <= alu_zero;
         rsp_id_q     <= id_q;
      end
   end

   assign rsp_result = rsp_result_q;
   assign rsp_zero   = rsp_zero_q;
   assign rsp_id     = rsp_id_q;

`ifdef ALU_ARB_STATS_EN
   logic [15:0] grant_count_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_count_q <= '0;
      end else if (rsp_valid && rsp_ready && (grant_count_q != 16'hFFFF)) begin
         grant_count_q <= grant_count_q + 16'd1;
      end
   end

   assign grant_count = grant_count_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;

   typedef struct {
      logic [1:0] id;
      logic [7:0] res;
      logic       z;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [31:0] req_a = '0;
   logic [31:0] req_b = '0;
   logic [11:0] req_op = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [1:0]  rsp_id;
   logic [7:0]  rsp_result;
   logic        rsp_zero;
`ifdef ALU_ARB_STATS_EN
   logic [15:0] grant_count;
`endif

   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   exp_t sb[$];

   alu_arbiter #(.NUM_REQ(4), .ID_W(2)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_a      (req_a),
      .req_b      (req_b),
      .req_op     (req_op),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_result (rsp_result),
      .rsp_zero   (rsp_zero)
`ifdef ALU_ARB_STATS_EN
      ,
      .grant_count(grant_count)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic exp_t model(input logic [1:0] id, input logic [7:0] a,
                                  input logic [7:0] b, input logic [2:0] op);
      exp_t e;
      case (op)
         3'd0:    e.res = a + b;
         3'd1:    e.res = a - b;
         3'd2:    e.res = a & b;
         3'd3:    e.res = a | b;
         default: e.res = 8'h00;
      endcase
      e.z  = (e.res == 8'h00);
      e.id = id;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ops(input int c, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op);
      req_a[c*8 +: 8]  = a;
      req_b[c*8 +: 8]  = b;
      req_op[c*3 +: 3] = op;
   endtask

   // Raise one client's request, wait (bounded) for its grant, push the
   // expected response, then drop the request after the accepting edge.
   task automatic issue(input int c, input logic [7:0] a, input logic [7:0] b,
                        input logic [2:0] op, output bit ok, output int acc,
                        output logic [3:0] rdy);
      ok  = 1'b0;
      acc = 0;
      rdy = '0;
      set_ops(c, a, b, op);
      req_valid[c] = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (req_ready[c]) begin
            ok  = 1'b1;
            acc = cyc;
            rdy = req_ready;
            break;
         end
         tick();
      end
      if (ok) sb.push_back(model(2'(c), a, b, op));
      tick();
      req_valid[c] = 1'b0;
   endtask

   task automatic wait_rsp(output bit ok, output int rc);
      ok = 1'b0;
      rc = 0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (rsp_valid) begin
            ok = 1'b1;
            rc = cyc;
            break;
         end
      end
   endtask

   task automatic pop_exp(output exp_t e);
      if (sb.size() > 0) e = sb.pop_front();
      else e = '{id: 2'bxx, res: 8'hxx, z: 1'bx};
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req_valid = 4'hF;
      repeat (2) @(posedge clk);
      @(negedge clk);
      total++; if (req_ready !== 4'b0000) begin bad++; $display("FAIL reset_ready got=%b want=0000", req_ready); end
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
      total++; if (rsp_id !== 2'd0) begin bad++; $display("FAIL reset_rsp_id got=%0d want=0", rsp_id); end
      total++; if (rsp_result !== 8'h00) begin bad++; $display("FAIL reset_rsp_result got=%h want=00", rsp_result); end
      total++; if (rsp_zero !== 1'b0) begin bad++; $display("FAIL reset_rsp_zero got=%b want=0", rsp_zero); end
`ifdef ALU_ARB_STATS_EN
      total++; if (grant_count !== 16'd0) begin bad++; $display("FAIL reset_grant_count got=%0d want=0", grant_count); end
`endif
      req_valid = '0;
      tick();
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_single();
      bit ok; int acc; int rc; logic [3:0] rdy; exp_t e;
      issue(2, 8'h05, 8'h03, 3'b000, ok, acc, rdy);
      total++; if (rdy !== 4'b0100) begin bad++; $display("FAIL single_ready got=%b want=0100", rdy); end
      wait_rsp(ok, rc);
      total++; if (!ok || (rc - acc) !== 2) begin bad++; $display("FAIL single_latency got=%0d want=2", rc - acc); end
      pop_exp(e);
      total++;
      if (rsp_id !== e.id || rsp_result !== e.res || rsp_zero !== e.z || e.res !== 8'h08) begin
         bad++;
         $display("FAIL single_rsp got=id%0d/%h/%b want=id%0d/%h/%b", rsp_id, rsp_result, rsp_zero, e.id, e.res, e.z);
      end
      tick();
   endtask

   task automatic test_sub();
      bit ok; int acc; int rc; logic [3:0] rdy; exp_t e;
      logic [7:0] av[2] = '{8'h10, 8'h00};
      logic [7:0] bv[2] = '{8'h10, 8'h01};
      for (int k = 0; k < 2; k++) begin
         issue(1, av[k], bv[k], 3'b001, ok, acc, rdy);
         wait_rsp(ok, rc);
         total++; if (!ok || (rc - acc) !== 2) begin bad++; $display("FAIL sub_latency[%0d] got=%0d want=2", k, rc - acc); end
         pop_exp(e);
         total++;
         if (rsp_id !== e.id || rsp_result !== e.res || rsp_zero !== e.z) begin
            bad++;
            $display("FAIL sub_rsp[%0d] got=id%0d/%h/%b want=id%0d/%h/%b", k, rsp_id, rsp_result, rsp_zero, e.id, e.res, e.z);
         end
         tick();
      end
   endtask

   task automatic test_reserved();
      bit ok; int acc; int rc; logic [3:0] rdy; exp_t e;
      issue(3, 8'hAA, 8'h55, 3'b110, ok, acc, rdy);
      wait_rsp(ok, rc);
      pop_exp(e);
      total++;
      if (!ok || rsp_result !== 8'h00 || rsp_zero !== 1'b1 || rsp_id !== e.id) begin
         bad++;
         $display("FAIL reserved_rsp got=id%0d/%h/%b want=id%0d/00/1", rsp_id, rsp_result, rsp_zero, e.id);
      end
      tick();
   endtask

   task automatic test_round_robin();
      int ngr = 0; int nrsp = 0; int last = 0;
      logic [3:0] want; exp_t e;
      rst_n = 1'b0;
      for (int c = 0; c < 4; c++) set_ops(c, 8'(8'h10 * c + 1), 8'(c), 3'(c));
      req_valid = 4'hF;
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 80 && nrsp < 8; i++) begin
         @(negedge clk);
         if (req_ready !== 4'b0000) begin
            want = 4'b0001 << (ngr % 4);
            total++; if (req_ready !== want) begin bad++; $display("FAIL rr_order[%0d] got=%b want=%b", ngr, req_ready, want); end
            if (ngr > 0) begin
               total++; if ((cyc - last) !== 3) begin bad++; $display("FAIL rr_spacing[%0d] got=%0d want=3", ngr, cyc - last); end
            end
            last = cyc;
            sb.push_back(model(2'(ngr % 4), 8'(8'h10 * (ngr % 4) + 1), 8'(ngr % 4), 3'(ngr % 4)));
            ngr++;
         end
         if (rsp_valid) begin
            pop_exp(e);
            total++;
            if (rsp_id !== e.id || rsp_result !== e.res || rsp_zero !== e.z) begin
               bad++;
               $display("FAIL rr_rsp[%0d] got=id%0d/%h/%b want=id%0d/%h/%b", nrsp, rsp_id, rsp_result, rsp_zero, e.id, e.res, e.z);
            end
            nrsp++;
         end
         tick();
         if (ngr >= 8) req_valid = '0;
      end
      total++; if (nrsp !== 8 || sb.size() !== 0) begin bad++; $display("FAIL rr_count got=%0d want=8", nrsp); end
      req_valid = '0;
   endtask

   task automatic test_back_pressure();
      bit ok; int acc; int rc; logic [3:0] rdy; exp_t e;
      logic [1:0] sid; logic [7:0] sres; logic sz;
      rsp_ready = 1'b0;
      issue(1, 8'h20, 8'h07, 3'b001, ok, acc, rdy);
      set_ops(3, 8'h0F, 8'hF0, 3'b011);
      req_valid[3] = 1'b1;
      wait_rsp(ok, rc);
      total++; if (!ok || (rc - acc) !== 2) begin bad++; $display("FAIL bp_latency got=%0d want=2", rc - acc); end
      pop_exp(e);
      total++;
      if (rsp_id !== e.id || rsp_result !== e.res || rsp_zero !== e.z) begin
         bad++;
         $display("FAIL bp_rsp got=id%0d/%h/%b want=id%0d/%h/%b", rsp_id, rsp_result, rsp_zero, e.id, e.res, e.z);
      end
      sid = rsp_id; sres = rsp_result; sz = rsp_zero;
      for (int k = 0; k < 5; k++) begin
         tick();
         @(negedge clk);
         total++;
         if (rsp_valid !== 1'b1 || rsp_id !== sid || rsp_result !== sres || rsp_zero !== sz || req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL bp_hold[%0d] got=v%b id%0d/%h/%b rdy=%b want=v1 id%0d/%h/%b rdy=0000", k, rsp_valid, rsp_id, rsp_result, rsp_zero, req_ready, sid, sres, sz);
         end
      end
      tick();
      rsp_ready = 1'b1;
      @(negedge clk);
      total++; if (rsp_valid !== 1'b1 || req_ready !== 4'b0000) begin bad++; $display("FAIL bp_handshake got=v%b rdy=%b want=v1 rdy=0000", rsp_valid, req_ready); end
      tick();
      @(negedge clk);
      total++; if (req_ready !== 4'b1000) begin bad++; $display("FAIL bp_resume got=%b want=1000", req_ready); end
      acc = cyc;
      sb.push_back(model(2'd3, 8'h0F, 8'hF0, 3'b011));
      tick();
      req_valid = '0;
      wait_rsp(ok, rc);
      pop_exp(e);
      total++;
      if (!ok || (rc - acc) !== 2 || rsp_id !== e.id || rsp_result !== e.res || rsp_zero !== e.z) begin
         bad++;
         $display("FAIL bp_next_rsp got=id%0d/%h/%b want=id%0d/%h/%b", rsp_id, rsp_result, rsp_zero, e.id, e.res, e.z);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      bit ok; int acc; int rc; logic [3:0] rdy; exp_t e;
      issue(1, 8'h01, 8'h01, 3'b000, ok, acc, rdy);
      rst_n = 1'b0;
      sb.delete();
      set_ops(0, 8'h40, 8'h02, 3'b000);
      set_ops(2, 8'h3C, 8'h0F, 3'b010);
      req_valid = 4'b0101;
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin bad++; $display("FAIL rmid_in_reset got=v%b rdy=%b want=v0 rdy=0000", rsp_valid, req_ready); end
      tick();
      @(negedge clk);
      total++; if (rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_no_rsp got=%b want=0", rsp_valid); end
`ifdef ALU_ARB_STATS_EN
      total++; if (grant_count !== 16'd0) begin bad++; $display("FAIL rmid_grant_count got=%0d want=0", grant_count); end
`endif
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      total++; if (req_ready !== 4'b0001 || rsp_valid !== 1'b0) begin bad++; $display("FAIL rmid_first_grant got=%b v%b want=0001 v0", req_ready, rsp_valid); end
      acc = cyc;
      sb.push_back(model(2'd0, 8'h40, 8'h02, 3'b000));
      tick();
      req_valid = '0;
      wait_rsp(ok, rc);
      pop_exp(e);
      total++;
      if (!ok || (rc - acc) !== 2 || rsp_id !== e.id || rsp_result !== e.res || rsp_zero !== e.z) begin
         bad++;
         $display("FAIL rmid_rsp got=id%0d/%h/%b want=id%0d/%h/%b", rsp_id, rsp_result, rsp_zero, e.id, e.res, e.z);
      end
      tick();
`ifdef ALU_ARB_STATS_EN
      @(negedge clk);
      total++; if (grant_count !== 16'd1) begin bad++; $display("FAIL rmid_count_after got=%0d want=1", grant_count); end
`endif
   endtask

   initial begin
      test_reset();
      test_single();
      test_sub();
      test_reserved();
      test_round_robin();
      test_back_pressure();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
